add_share_arbiter: RTL
======================

// Module: add_share_arbiter
// PURPOSE
//   Shares one WIDTH-bit adder between two requesters using round-robin arbitration.
//   Each requester presents an operand pair (a,b) on a valid/ready handshake.
//   The granted pair is added and registered into a single result slot with the sum,
//   carry-out and requester id, then drained by a downstream valid/ready consumer.
//   Sits between the pin-level input mux and the uo_out driver in the top-level tile.
// PARAMETERS
//   WIDTH    8    operand and sum width in bits
//   CNT_W    16   width of the completed-operation counter
// PORTS
//   clk          in   1      single clock; all state updates on its rising edge
//   rst          in   1      reset; synchronous, active-high
//   req0_valid   in   1      requester 0 has an operand pair
//   req0_a       in   WIDTH  requester 0 operand a
//   req0_b       in   WIDTH  requester 0 operand b
//   req0_ready   out  1      requester 0 pair accepted this cycle (valid & ready)
//   req1_valid   in   1      requester 1 has an operand pair
//   req1_a       in   WIDTH  requester 1 operand a
//   req1_b       in   WIDTH  requester 1 operand b
//   req1_ready   out  1      requester 1 pair accepted this cycle
//   res_valid    out  1      result slot holds an unconsumed result
//   res_ready    in   1      consumer takes the result this cycle
//   res_sum      out  WIDTH  (a+b) mod 2^WIDTH
//   res_carry    out  1      bit WIDTH of a+b
//   res_id       out  1      requester that produced the result (0/1)
//   ops_cnt      out  CNT_W  count of results consumed; wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//   - Reset: res_valid=0, res_sum=0, res_carry=0, res_id=0, ops_cnt=0, last_grant=1
//     (so req0 wins the first contention); req*_ready=0 while rst=1.
//   - Slot free: res_valid=0, or (ADD_SHARE_PIPE_EN only) res_valid & res_ready.
//   - Grant (combinational): slot free and exactly one valid -> that requester;
//     both valid -> requester != last_grant; none valid -> no grant.
//   - reqN_ready = grant==N; depends on valid and slot state only.
//     reqN_valid must not depend on reqN_ready; once asserted, the requester holds
//     valid and operands stable until the handshake completes.
//   - On accept: res_sum/res_carry <= {carry,sum} of the WIDTH+1-bit sum a+b;
//     res_id <= N; last_grant <= N; res_valid <= 1 on the next edge.
//     Latency: result visible the cycle after the accept.
//   - Result hold: while res_valid & !res_ready, res_sum/res_carry/res_id stay stable
//     and no new pair is accepted.
//   - On consume (res_valid & res_ready): ops_cnt increments mod 2^CNT_W;
//     res_valid <= 0 unless a new accept happens in the same cycle.
//   - Only one valid: that requester is granted regardless of last_grant.
//     The pointer still updates, so no starvation under continuous contention.
//   - Reset mid-operation: pending result discarded; no ready pulse in the reset cycle.
//   - Example: 8'hFF + 8'h01 -> res_sum=8'h00, res_carry=1.
// CONFIGURATION
//   ADD_SHARE_PIPE_EN defined: consume and accept may coincide; the result is replaced
//     at the next edge, giving one result per cycle under continuous demand.
//   ADD_SHARE_PIPE_EN undefined: accept only when res_valid=0; at most one result per
//     two cycles; ready is never asserted in a cycle with res_valid=1.
// TESTING
//   1 reset: rst=1 for 2 cycles with both valid=1 -> all outputs 0, no ready pulse.
//   2 req0 only, a=8'h12 b=8'h34, res_ready=1 -> req0_ready 1 cycle; next cycle
//     res_valid=1, sum=8'h46, carry=0, id=0; ops_cnt=1 after the consume.
//   3 both valid held 6 results, res_ready=1 -> ids alternate 0,1,0,1,0,1.
//     Spacing: every cycle with PIPE_EN, every other cycle without.
//   4 req1 a=8'hFF b=8'h01, res_ready=0 for 4 cycles -> sum=8'h00, carry=1, id=1 held;
//     both ready=0 throughout; the result drains on the first res_ready=1.
//   5 pre-load ops_cnt to 16'hFFFF via 65535 consumes (or force), one more consume
//     -> ops_cnt=16'h0000.
//   6 rst pulsed while res_valid=1 -> next cycle res_valid=0, ops_cnt=0, last_grant=1.

Source files
------------

// File: rtl/add_share_arbiter.sv
// Purpose: two requesters share one WIDTH-bit adder under round-robin arbitration;
//          the granted pair's sum/carry/id lands in a single result slot drained by valid/ready.
// Latency: result visible the cycle after the accept; optional macro ADD_SHARE_PIPE_EN
//          lets a consume and a new accept coincide (one result per cycle), otherwise one per two.
// Ports:   clk, rst (sync, active-high); req0_*/req1_* operand handshakes;
//          res_* result handshake with sum, carry, id; ops_cnt counts consumed results.
module add_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id,
    output logic [CNT_W-1:0] ops_cnt
);

    logic             res_valid_q,  res_valid_d;
    logic [WIDTH-1:0] res_sum_q,    res_sum_d;
    logic             res_carry_q,  res_carry_d;
    logic             res_id_q,     res_id_d;
    logic [CNT_W-1:0] ops_cnt_q,    ops_cnt_d;
    logic             last_grant_q, last_grant_d;

    logic             slot_free;
    logic             consume;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH:0]   sum_full;

    always_comb begin
        consume = res_valid_q & res_ready;

`ifdef ADD_SHARE_PIPE_EN
        // A result leaving this cycle frees the slot for a same-cycle accept.
        slot_free = ~res_valid_q | res_ready;
`else
        slot_free = ~res_valid_q;
`endif

        // With both requesting, the one not granted last time wins; a lone
        // requester wins regardless of the pointer. No grant during reset.
        gnt0 = ~rst & slot_free & req0_valid & (~req1_valid | last_grant_q);
        gnt1 = ~rst & slot_free & req1_valid & (~req0_valid | ~last_grant_q);

        sel_a    = gnt1 ? req1_a : req0_a;
        sel_b    = gnt1 ? req1_b : req0_b;
        sum_full = {1'b0, sel_a} + {1'b0, sel_b};

        res_valid_d  = res_valid_q;
        res_sum_d    = res_sum_q;
        res_carry_d  = res_carry_q;
        res_id_d     = res_id_q;
        ops_cnt_d    = ops_cnt_q;
        last_grant_d = last_grant_q;

        if (consume) begin
            ops_cnt_d   = ops_cnt_q + CNT_W'(1);
            res_valid_d = 1'b0;
        end

        // An accept overrides the clear from a coincident consume.
        if (gnt0 | gnt1) begin
            res_valid_d  = 1'b1;
            res_sum_d    = sum_full[WIDTH-1:0];
            res_carry_d  = sum_full[WIDTH];
            res_id_d     = gnt1;
            last_grant_d = gnt1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q  <= 1'b0;
            res_sum_q    <= '0;
            res_carry_q  <= 1'b0;
            res_id_q     <= 1'b0;
            ops_cnt_q    <= '0;
            last_grant_q <= 1'b1;   // req0 wins the first contention
        end else begin
            res_valid_q  <= res_valid_d;
            res_sum_q    <= res_sum_d;
            res_carry_q  <= res_carry_d;
            res_id_q     <= res_id_d;
            ops_cnt_q    <= ops_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign res_valid  = res_valid_q;
    assign res_sum    = res_sum_q;
    assign res_carry  = res_carry_q;
    assign res_id     = res_id_q;
    assign ops_cnt    = ops_cnt_q;

endmodule
